// File: rtl/fasm_tdpram_be_if.sv
// fasm_tdpram_be bus bundle: port A (dat/adr/...) and port X (xdat/xadr/...)
// plus the collision flag; master drives requests, slave is the RAM.
interface fasm_tdpram_be_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [DW-1:0]   dat_i;
  logic [AW-1:0]   adr_i;
  logic            wre_i;
  logic [DW/8-1:0] sel_i;
  logic            stb_i;
  logic [DW-1:0]   dat_o;
  logic            ack_o;
  logic [DW-1:0]   xdat_i;
  logic [AW-1:0]   xadr_i;
  logic            xwre_i;
  logic [DW/8-1:0] xsel_i;
  logic            xstb_i;
  logic [DW-1:0]   xdat_o;
  logic            xack_o;
  logic            col_o;

  modport master (
    output dat_i, adr_i, wre_i, sel_i, stb_i,
    output xdat_i, xadr_i, xwre_i, xsel_i, xstb_i,
    input  dat_o, ack_o, xdat_o, xack_o, col_o
  );

  modport slave (
    input  dat_i, adr_i, wre_i, sel_i, stb_i,
    input  xdat_i, xadr_i, xwre_i, xsel_i, xstb_i,
    output dat_o, ack_o, xdat_o, xack_o, col_o
  );
endinterface

// File: rtl/fasm_tdpram_be.sv
// True dual-port byte-enable RAM, per-port read mode and optional out reg.
// FASM_BYPASS_EN: reader sees the merged word on a write/read collision.
module fasm_tdpram_be #(
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int MODE = 0,
  parameter int OREG = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  fasm_tdpram_be_if.slave bus
);
  localparam int NL = DW / 8;

  logic [DW-1:0] mem_q [2**AW];

  logic          wa, wx, same, col;
  logic [DW-1:0] old_a, old_x;
  logic [DW-1:0] mrg_a, mrg_x;
  logic [DW-1:0] byp_a, byp_x;
  logic [DW-1:0] dat_d, xdat_d;
  logic          lda, ldx;
  logic [DW-1:0] dat_q, xdat_q;
  logic          ack_q, xack_q, col_q;

  function automatic logic [DW-1:0] lanes(
    input logic [DW-1:0] w,
    input logic [DW-1:0] d,
    input logic [NL-1:0] s
  );
    logic [DW-1:0] r;
    r = w;
    for (int k = 0; k < NL; k++)
      if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  assign wa    = bus.stb_i & bus.wre_i & ~rst_i;
  assign wx    = bus.xstb_i & bus.xwre_i & ~rst_i;
  assign same  = bus.adr_i == bus.xadr_i;
  assign col   = bus.stb_i & bus.xstb_i & same
               & (bus.wre_i | bus.xwre_i);
  assign old_a = mem_q[bus.adr_i];
  assign old_x = mem_q[bus.xadr_i];
  assign mrg_a = lanes(old_a, bus.dat_i, bus.sel_i);
  assign mrg_x = lanes(old_x, bus.xdat_i, bus.xsel_i);

`ifdef FASM_BYPASS_EN
  logic [DW-1:0] fin;
  // A applied last so it owns the lanes both ports select
  assign fin   = lanes(lanes(old_a, bus.xdat_i, wx ? bus.xsel_i : '0),
                       bus.dat_i, wa ? bus.sel_i : '0);
  assign byp_a = (col & wx) ? fin : old_a;
  assign byp_x = (col & wa) ? fin : old_x;
`else
  assign byp_a = old_a;
  assign byp_x = old_x;
`endif

  always_comb begin
    dat_d = dat_q;
    if (!bus.wre_i) dat_d = byp_a;
    else if (MODE == 0) dat_d = mrg_a;
    else if (MODE == 1) dat_d = old_a;
  end

  always_comb begin
    xdat_d = xdat_q;
    if (!bus.xwre_i) xdat_d = byp_x;
    else if (MODE == 0) xdat_d = mrg_x;
    else if (MODE == 1) xdat_d = old_x;
  end

  assign lda = bus.stb_i & ~(bus.wre_i & (MODE == 2));
  assign ldx = bus.xstb_i & ~(bus.xwre_i & (MODE == 2));

  always_ff @(posedge clk_i) begin
    if (wx)
      for (int k = 0; k < NL; k++)
        if (bus.xsel_i[k])
          mem_q[bus.xadr_i][8*k +: 8] <= bus.xdat_i[8*k +: 8];
    if (wa)
      for (int k = 0; k < NL; k++)
        if (bus.sel_i[k])
          mem_q[bus.adr_i][8*k +: 8] <= bus.dat_i[8*k +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_q  <= '0;
      xdat_q <= '0;
      ack_q  <= 1'b0;
      xack_q <= 1'b0;
      col_q  <= 1'b0;
    end else begin
      ack_q  <= bus.stb_i;
      xack_q <= bus.xstb_i;
      col_q  <= col;
      if (lda) dat_q <= dat_d;
      if (ldx) xdat_q <= xdat_d;
    end
  end

  assign bus.col_o = col_q;

  if (OREG != 0) begin : g_oreg
    logic [DW-1:0] dat2_q, xdat2_q;
    logic          ack2_q, xack2_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dat2_q  <= '0;
        xdat2_q <= '0;
        ack2_q  <= 1'b0;
        xack2_q <= 1'b0;
      end else begin
        ack2_q  <= ack_q;
        xack2_q <= xack_q;
        if (ack_q) dat2_q <= dat_q;
        if (xack_q) xdat2_q <= xdat_q;
      end
    end
    assign bus.dat_o  = dat2_q;
    assign bus.xdat_o = xdat2_q;
    assign bus.ack_o  = ack2_q;
    assign bus.xack_o = xack2_q;
  end else begin : g_noreg
    assign bus.dat_o  = dat_q;
    assign bus.xdat_o = xdat_q;
    assign bus.ack_o  = ack_q;
    assign bus.xack_o = xack_q;
  end
endmodule

// File: tb/tb_fasm_tdpram_be.sv
// Bench for fasm_tdpram_be: four instances (MODE 0/1/2 OREG 0, MODE 0 OREG 1)
// against a word-array model, plus a directed vector table.
module tb_fasm_tdpram_be;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NI = 4;
`ifdef FASM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic as = 0, aw = 0, xs = 0, xw = 0;
  logic [7:0] aa = 0, xa = 0;
  logic [31:0] ad = 0, xd = 0;
  logic [3:0] asl = 0, xsl = 0;

  logic [31:0] o_dat [NI];
  logic [31:0] o_xdat [NI];
  logic o_ack [NI];
  logic o_xack [NI];
  logic o_col [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fasm_tdpram_be_if #(.AW(AW), .DW(DW)) bi ();
    assign bi.dat_i  = ad;
    assign bi.adr_i  = aa;
    assign bi.wre_i  = aw;
    assign bi.sel_i  = asl;
    assign bi.stb_i  = as;
    assign bi.xdat_i = xd;
    assign bi.xadr_i = xa;
    assign bi.xwre_i = xw;
    assign bi.xsel_i = xsl;
    assign bi.xstb_i = xs;
    assign o_dat[g]  = bi.dat_o;
    assign o_xdat[g] = bi.xdat_o;
    assign o_ack[g]  = bi.ack_o;
    assign o_xack[g] = bi.xack_o;
    assign o_col[g]  = bi.col_o;
    fasm_tdpram_be #(
      .AW(AW), .DW(DW),
      .MODE((g == 3) ? 0 : g),
      .OREG((g == 3) ? 1 : 0)
    ) u_dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bi.slave)
    );
  end

  typedef struct {
    int due;
    bit hold;
    logic [31:0] v;
  } ev_t;

  logic [31:0] ref_m [256];
  ev_t qa [NI][$];
  ev_t qx [NI][$];
  logic [31:0] exp_da [NI];
  logic [31:0] exp_dx [NI];
  bit exp_col;
  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] @%0d got %h want %h", nm, i, cyc, act, exp);
  endtask

  function automatic logic [31:0] put(input logic [31:0] w,
                                      input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < 4; k++)
      if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // One clock: predict from the current inputs, clock, compare everything.
  task automatic cyc_step();
    logic [31:0] oa, ox, na, nx;
    bit c;
    ev_t e;
    int m, lat;
    c = 0;
    if (!rst) begin
      oa = ref_m[aa];
      ox = ref_m[xa];
      if (xs && xw) ref_m[xa] = put(ref_m[xa], xd, xsl);
      if (as && aw) ref_m[aa] = put(ref_m[aa], ad, asl);
      na = ref_m[aa];
      nx = ref_m[xa];
      c = as && xs && (aa == xa) && (aw || xw);
      for (int i = 0; i < NI; i++) begin
        m = (i == 3) ? 0 : i;
        lat = (i == 3) ? 2 : 1;
        if (as) begin
          e.due = cyc + lat; e.hold = 0; e.v = oa;
          if (!aw) e.v = BYP ? na : oa;
          else if (m == 0) e.v = put(oa, ad, asl);
          else if (m == 2) e.hold = 1;
          qa[i].push_back(e);
        end
        if (xs) begin
          e.due = cyc + lat; e.hold = 0; e.v = ox;
          if (!xw) e.v = BYP ? nx : ox;
          else if (m == 0) e.v = put(ox, xd, xsl);
          else if (m == 2) e.hold = 1;
          qx[i].push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_col = c;
    for (int i = 0; i < NI; i++) begin
      bit ea, ex;
      if (rst) begin
        qa[i].delete(); qx[i].delete();
        exp_da[i] = 0; exp_dx[i] = 0;
      end
      ea = (qa[i].size() > 0) && (qa[i][0].due == cyc);
      ex = (qx[i].size() > 0) && (qx[i][0].due == cyc);
      if (ea) begin
        e = qa[i].pop_front();
        if (!e.hold) exp_da[i] = e.v;
      end
      if (ex) begin
        e = qx[i].pop_front();
        if (!e.hold) exp_dx[i] = e.v;
      end
      chk("ack", i, {31'b0, o_ack[i]}, {31'b0, ea});
      chk("xack", i, {31'b0, o_xack[i]}, {31'b0, ex});
      chk("col", i, {31'b0, o_col[i]}, {31'b0, exp_col});
      chk("dat", i, o_dat[i], exp_da[i]);
      chk("xdat", i, o_xdat[i], exp_dx[i]);
    end
  endtask

  task automatic idle();
    as = 0; aw = 0; xs = 0; xw = 0; asl = 0; xsl = 0;
  endtask

  typedef struct {
    bit as, aw; logic [7:0] aa; logic [31:0] ad; logic [3:0] asl;
    bit xs, xw; logic [7:0] xa; logic [31:0] xd; logic [3:0] xsl;
    bit cd; logic [31:0] ed;
    bit cx; logic [31:0] ex;
    bit ea, exa, ec;
  } vec_t;

  vec_t tv [13];

  initial begin
    logic [31:0] wr_exp;
    wr_exp = BYP ? 32'hCAFEF00D : 32'h12345678;
    tv[0]  = '{1,1,8'h10,32'h11223344,4'hF, 0,0,8'h00,32'h0,4'h0, 1,32'h11223344, 0,32'h0, 1,0,0};
    tv[1]  = '{1,1,8'h10,32'hAABBCCDD,4'h5, 0,0,8'h00,32'h0,4'h0, 1,32'h11BB33DD, 0,32'h0, 1,0,0};
    tv[2]  = '{0,0,8'h00,32'h0,4'h0, 1,0,8'h10,32'h0,4'h0, 0,32'h0, 1,32'h11BB33DD, 0,1,0};
    tv[3]  = '{0,0,8'h00,32'h0,4'h0, 1,1,8'h05,32'h1,4'hF, 0,32'h0, 1,32'h1, 0,1,0};
    tv[4]  = '{1,0,8'h10,32'h0,4'h0, 0,0,8'h00,32'h0,4'h0, 1,32'h11BB33DD, 0,32'h0, 1,0,0};
    tv[5]  = '{1,1,8'h05,32'hFF,4'hF, 0,0,8'h00,32'h0,4'h0, 1,32'hFF, 0,32'h0, 1,0,0};
    tv[6]  = '{1,1,8'h20,32'h77665544,4'hF, 0,0,8'h00,32'h0,4'h0, 1,32'h77665544, 0,32'h0, 1,0,0};
    tv[7]  = '{1,1,8'h20,32'hAAAAAAAA,4'h3, 1,1,8'h20,32'hBBBBBBBB,4'h6, 1,32'h7766AAAA, 1,32'h77BBBB44, 1,1,1};
    tv[8]  = '{1,0,8'h20,32'h0,4'h0, 0,0,8'h00,32'h0,4'h0, 1,32'h77BBAAAA, 0,32'h0, 1,0,0};
    tv[9]  = '{1,1,8'h30,32'h12345678,4'hF, 0,0,8'h00,32'h0,4'h0, 1,32'h12345678, 0,32'h0, 1,0,0};
    tv[10] = '{1,1,8'h30,32'hCAFEF00D,4'hF, 1,0,8'h30,32'h0,4'h0, 1,32'hCAFEF00D, 1,wr_exp, 1,1,1};
    tv[11] = '{0,0,8'h00,32'h0,4'h0, 1,0,8'h30,32'h0,4'h0, 0,32'h0, 1,32'hCAFEF00D, 0,1,0};
    tv[12] = '{1,0,8'h30,32'h0,4'h0, 1,0,8'h30,32'h0,4'h0, 1,32'hCAFEF00D, 1,32'hCAFEF00D, 1,1,0};

    for (int i = 0; i < NI; i++) begin
      exp_da[i] = 0; exp_dx[i] = 0;
    end
    for (int i = 0; i < 256; i++) ref_m[i] = 0;

    rst = 1; idle();
    repeat (3) cyc_step();
    rst = 0;

    // fill the whole array so every later read is predictable
    for (int i = 0; i < 128; i++) begin
      as = 1; aw = 1; aa = 8'(i); ad = $urandom; asl = 4'hF;
      xs = 1; xw = 1; xa = 8'(i + 128); xd = $urandom; xsl = 4'hF;
      cyc_step();
    end

    // reset with both strobes held high, then release
    rst = 1;
    as = 1; aw = 0; aa = 8'h01; xs = 1; xw = 0; xa = 8'h02;
    aw = 0; asl = 0; xsl = 0;
    for (int i = 0; i < 2; i++) begin
      cyc_step();
      chk("rst_dat", i, o_dat[0], 32'h0);
      chk("rst_xdat", i, o_xdat[0], 32'h0);
      chk("rst_ack", i, {31'b0, o_ack[0] | o_xack[0]}, 32'h0);
      chk("rst_col", i, {31'b0, o_col[0]}, 32'h0);
    end
    rst = 0;
    cyc_step();
    chk("first_ack", 0, {31'b0, o_ack[0]}, 32'h1);
    chk("first_xack", 0, {31'b0, o_xack[0]}, 32'h1);
    chk("first_dat", 0, o_dat[0], ref_m[1]);
    idle();
    cyc_step();

    for (int r = 0; r < 13; r++) begin
      as = tv[r].as; aw = tv[r].aw; aa = tv[r].aa;
      ad = tv[r].ad; asl = tv[r].asl;
      xs = tv[r].xs; xw = tv[r].xw; xa = tv[r].xa;
      xd = tv[r].xd; xsl = tv[r].xsl;
      cyc_step();
      chk("v_ack", r, {31'b0, o_ack[0]}, {31'b0, tv[r].ea});
      chk("v_xack", r, {31'b0, o_xack[0]}, {31'b0, tv[r].exa});
      chk("v_col", r, {31'b0, o_col[0]}, {31'b0, tv[r].ec});
      if (tv[r].cd) chk("v_dat", r, o_dat[0], tv[r].ed);
      if (tv[r].cx) chk("v_xdat", r, o_xdat[0], tv[r].ex);
      if (r == 5) begin
        chk("m1_rdfirst", r, o_dat[1], 32'h1);
        chk("m2_hold", r, o_dat[2], 32'h11BB33DD);
      end
    end
    idle();
    cyc_step();

    // OREG=1 pipeline with reset landing mid-burst
    for (int s = 0; s < 6; s++) begin
      idle();
      rst = (s == 3);
      if (s < 4) begin as = 1; aa = 8'(s); end
      cyc_step();
      if (s == 1 || s == 2) begin
        chk("oreg_ack", s, {31'b0, o_ack[3]}, 32'h1);
        chk("oreg_dat", s, o_dat[3], ref_m[s - 1]);
      end else begin
        chk("oreg_noack", s, {31'b0, o_ack[3]}, 32'h0);
      end
    end
    rst = 0;

    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      as = $urandom_range(0, 1); aw = $urandom_range(0, 1);
      xs = $urandom_range(0, 1); xw = $urandom_range(0, 1);
      aa = 8'($urandom_range(0, 15));
      xa = $urandom_range(0, 1) ? aa : 8'($urandom_range(0, 15));
      ad = $urandom; xd = $urandom;
      asl = 4'($urandom); xsl = 4'($urandom);
      cyc_step();
    end
    rst = 0; idle();
    repeat (3) cyc_step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
